// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and constants for the JK excitation driver: FSM states,
// 2-bit {j,k} excitation codes and the retry counter width.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Excitation codes are packed as {j, k}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Controller-facing handshake plus JK bank wiring for jk_excitation_driver.
// Handshake: a target transfers on the rising edge where tgt_valid && tgt_ready;
// tgt_ready is low while a transfer is in flight and tgt_valid is then ignored.
interface jk_excitation_driver_if #(
  parameter int N = 4
) ();
  import jk_pkg::*;

  logic [N-1:0]         tgt;
  logic                 tgt_valid;
  logic                 tgt_ready;
  logic [N-1:0]         q_fb;
  logic [N-1:0]         j;
  logic [N-1:0]         k;
  logic                 done;
  logic                 err;
  logic [RETRY_W-1:0]   retry_cnt;
  state_t               state_dbg;

  modport master (
    output tgt, tgt_valid, q_fb,
    input  tgt_ready, j, k, done, err, retry_cnt, state_dbg
  );

  modport slave (
    input  tgt, tgt_valid, q_fb,
    output tgt_ready, j, k, done, err, retry_cnt, state_dbg
  );

endinterface

// File: rtl/jk_excitation_driver_excite_bit.sv
// Per-bit JK excitation from current Q and target. Set/reset excitation by
// default; with JK_TOGGLE_EN defined, changing bits are toggled with 11.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q,
  input  logic tgt,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = JK_HOLD;
`ifdef JK_TOGGLE_EN
    if (q != tgt) jk = JK_TGL;
`else
    if (!q && tgt)      jk = JK_SET;
    else if (q && !tgt) jk = JK_RST;
`endif
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external N-bit JK bank toward a target word, verifies the result and
// retries up to MAX_RETRY times. Optional toggle excitation via JK_TOGGLE_EN.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_excitation_driver_if.slave bus
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [N-1:0]         tgt_q, tgt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [N-1:0]         j_q, j_d;
  logic [N-1:0]         k_q, k_d;
  logic [N-1:0]         exc_tgt, exc_j, exc_k;
  logic                 match;
  logic                 done_c, err_c;

  // On accept the capture register is not yet loaded, so excite from the live input.
  assign exc_tgt = (state_q == IDLE) ? bus.tgt : tgt_q;
  assign match   = (bus.q_fb == tgt_q);

  for (genvar i = 0; i < N; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q   (bus.q_fb[i]),
      .tgt (exc_tgt[i]),
      .j   (exc_j[i]),
      .k   (exc_k[i])
    );
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt;
          retry_d = '0;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (match) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + 1'b1;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          err_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.retry_cnt = retry_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank model.
module tb_jk_excitation_driver;
  import jk_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] q_bank = '0;
  logic [N-1:0] preset_val = '0;
  logic         preset_en = 1'b0;
  logic         stuck = 1'b0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  jk_excitation_driver_if #(.N(N)) bus ();

  jk_excitation_driver #(.N(N), .MAX_RETRY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural JK bank: 00 hold, 10 set, 01 reset, 11 toggle.
  always @(posedge clk) begin
    if (preset_en) q_bank <= preset_val;
    else if (!stuck) begin
      for (int b = 0; b < N; b++) begin
        case ({bus.j[b], bus.k[b]})
          2'b10:   q_bank[b] <= 1'b1;
          2'b01:   q_bank[b] <= 1'b0;
          2'b11:   q_bank[b] <= ~q_bank[b];
          default: q_bank[b] <= q_bank[b];
        endcase
      end
    end
  end
  assign bus.q_fb = q_bank;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [N-1:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    tick();
    preset_en  = 1'b0;
  endtask

  // Presents one word for a single accept edge; returns in the DRIVE cycle.
  task automatic send(input logic [N-1:0] v);
    bus.tgt       = v;
    bus.tgt_valid = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
  endtask

  logic [N-1:0] exp_j, exp_k;
  int drives, dones, errs;
  logic [RETRY_W-1:0] retry_at_err;

  initial begin
    bus.tgt       = '0;
    bus.tgt_valid = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_ready", 32'(bus.tgt_ready), 32'd1);
    check_eq("rst_j", 32'(bus.j), 32'd0);
    check_eq("rst_k", 32'(bus.k), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_retry", 32'(bus.retry_cnt), 32'd0);
    check_eq("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Basic set: 0000 -> 1010
    preset(4'b0000);
    send(4'b1010);
    check_eq("basic_j", 32'(bus.j), 32'b1010);
    check_eq("basic_k", 32'(bus.k), 32'b0000);
    check_eq("basic_ready", 32'(bus.tgt_ready), 32'd0);
    check_eq("basic_state", 32'(bus.state_dbg), 32'(DRIVE));
    check_eq("basic_done_early", 32'(bus.done), 32'd0);
    tick();
    check_eq("basic_jk_clear", 32'({bus.j, bus.k}), 32'd0);
    check_eq("basic_done", 32'(bus.done), 32'd1);
    check_eq("basic_err", 32'(bus.err), 32'd0);
    check_eq("basic_retry", 32'(bus.retry_cnt), 32'd0);
    tick();
    check_eq("basic_ready_back", 32'(bus.tgt_ready), 32'd1);
    check_eq("basic_done_gone", 32'(bus.done), 32'd0);

    // Mixed hold: 1100 -> 1010
    preset(4'b1100);
    send(4'b1010);
`ifdef JK_TOGGLE_EN
    exp_j = 4'b0110; exp_k = 4'b0110;
`else
    exp_j = 4'b0010; exp_k = 4'b0100;
`endif
    check_eq("mixed_j", 32'(bus.j), 32'(exp_j));
    check_eq("mixed_k", 32'(bus.k), 32'(exp_k));
    tick();
    check_eq("mixed_jk_clear", 32'({bus.j, bus.k}), 32'd0);
    check_eq("mixed_done", 32'(bus.done), 32'd1);
    tick();

    // Toggle vector: 0110 -> 0011
    preset(4'b0110);
    send(4'b0011);
`ifdef JK_TOGGLE_EN
    exp_j = 4'b0101; exp_k = 4'b0101;
`else
    exp_j = 4'b0001; exp_k = 4'b0100;
`endif
    check_eq("tgl_j", 32'(bus.j), 32'(exp_j));
    check_eq("tgl_k", 32'(bus.k), 32'(exp_k));
    check_eq("tgl_hold_bits", 32'((bus.j & bus.k) & 4'b1010), 32'd0);
    tick();
    check_eq("tgl_done", 32'(bus.done), 32'd1);
    tick();

    // Stuck bank: three drive pulses, then err with retry_cnt=2
    preset(4'b0000);
    stuck = 1'b1;
    repeat (3) exp_q.push_back(4'b0001);
    send(4'b0001);
    drives = 0; dones = 0; errs = 0; retry_at_err = '0;
    for (int c = 0; c < 6; c++) begin
      if (bus.j != '0) begin
        drives++;
        if (exp_q.size() > 0) check_eq("stuck_drive_j", 32'(bus.j), 32'(exp_q.pop_front()));
        else check_eq("stuck_extra_drive", 32'(bus.j), 32'd0);
      end
      if (bus.done) dones++;
      if (bus.err) begin
        errs++;
        retry_at_err = bus.retry_cnt;
      end
      tick();
    end
    check_eq("stuck_drives", 32'(drives), 32'd3);
    check_eq("stuck_dones", 32'(dones), 32'd0);
    check_eq("stuck_errs", 32'(errs), 32'd1);
    check_eq("stuck_retry_at_err", 32'(retry_at_err), 32'd2);
    check_eq("stuck_ready_after", 32'(bus.tgt_ready), 32'd1);
    check_eq("stuck_retry_hold", 32'(bus.retry_cnt), 32'd2);
    check_eq("stuck_err_gone", 32'(bus.err), 32'd0);
    stuck = 1'b0;
    exp_q.delete();

    // Reset during DRIVE aborts the transfer
    preset(4'b0000);
    send(4'b1111);
    check_eq("abort_drive_j", 32'(bus.j), 32'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_jk", 32'({bus.j, bus.k}), 32'd0);
    check_eq("abort_ready", 32'(bus.tgt_ready), 32'd1);
    check_eq("abort_done_err", 32'({bus.done, bus.err}), 32'd0);
    check_eq("abort_retry", 32'(bus.retry_cnt), 32'd0);
    preset(4'b0000);
    send(4'b1111);
    check_eq("after_abort_j", 32'(bus.j), 32'b1111);
    tick();
    check_eq("after_abort_done", 32'(bus.done), 32'd1);
    tick();

    // Backpressure: valid held high, words change while busy
    preset(4'b0000);
    bus.tgt = 4'b0101;
    bus.tgt_valid = 1'b1;
    tick();
    bus.tgt = 4'b1010;
    check_eq("bp_first_j", 32'(bus.j), 32'b0101);
    check_eq("bp_busy_ready", 32'(bus.tgt_ready), 32'd0);
    tick();
    bus.tgt = 4'b0011;
    check_eq("bp_done", 32'(bus.done), 32'd1);
    check_eq("bp_jk_idle", 32'({bus.j, bus.k}), 32'd0);
    tick();
    bus.tgt = 4'b1100;
    check_eq("bp_ready", 32'(bus.tgt_ready), 32'd1);
    check_eq("bp_no_drive_in_idle", 32'({bus.j, bus.k}), 32'd0);
    tick();
    bus.tgt_valid = 1'b0;
`ifdef JK_TOGGLE_EN
    exp_j = 4'b1001; exp_k = 4'b1001;
`else
    exp_j = 4'b1000; exp_k = 4'b0001;
`endif
    check_eq("bp_second_j", 32'(bus.j), 32'(exp_j));
    check_eq("bp_second_k", 32'(bus.k), 32'(exp_k));
    tick();
    check_eq("bp_second_done", 32'(bus.done), 32'd1);
    check_eq("bp_bank", 32'(q_bank), 32'b1100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
